// File: rtl/regwrite_sequencer_if.sv
// regwrite_sequencer_if: request/write-port bundle between the write-back
// sources, the sequencer and the register bank write port.
//   req_valid/req_dest/wb_hold : requester side into the sequencer
//   req_ready                  : one-hot combinational grant back to sources
//   wd_sel/wr_reg/reg_wr       : registered write port toward the bank + mux
//   init_done/wr_count         : status
// slave  = sequencer view, master = control-unit / requester view.
interface regwrite_sequencer_if #(
  parameter int NUM_SRC = 7
);
  logic [NUM_SRC-1:0]   req_valid;
  logic [NUM_SRC*5-1:0] req_dest;
  logic                 wb_hold;
  logic [NUM_SRC-1:0]   req_ready;
  logic [2:0]           wd_sel;
  logic [4:0]           wr_reg;
  logic                 reg_wr;
  logic                 init_done;
  logic [15:0]          wr_count;

  modport slave (
    input  req_valid, req_dest, wb_hold,
    output req_ready, wd_sel, wr_reg, reg_wr, init_done, wr_count
  );

  modport master (
    output req_valid, req_dest, wb_hold,
    input  req_ready, wd_sel, wr_reg, reg_wr, init_done, wr_count
  );
endinterface

// File: rtl/regwrite_sequencer.sv
// regwrite_sequencer: owns the single register-bank write port.
// After every reset it issues one stack-pointer init write (mux input 7,
// destination SP_REG), then arbitrates NUM_SRC write-back sources (mux
// inputs 0..6) with round-robin or fixed-priority selection.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      regwrite_sequencer_if.slave (requests in, grant + write port out)
module regwrite_sequencer #(
  parameter int NUM_SRC = 7,
  parameter int SP_REG  = 29,
  parameter bit RR_MODE = 1'b1
) (
  input logic clk,
  input logic reset_n,
  regwrite_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_INIT, S_INIT_WR, S_ARB} state_t;

  state_t             state, state_nx;
  logic [2:0]         rr_ptr;
  logic [NUM_SRC-1:0] gnt;
  logic [2:0]         win;
  logic [4:0]         win_dest;
  logic               hit;

  // Grant: scan starting at rr_ptr (round-robin) or at 0 (fixed priority),
  // first valid source wins. Only S_ARB can grant, so the grant is
  // inherently zero during reset and the init sequence.
  always_comb begin
    int j;
    gnt      = '0;
    win      = '0;
    win_dest = '0;
    hit      = 1'b0;
    j        = 0;
    if (state == S_ARB && !bus.wb_hold) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        j = RR_MODE ? int'(rr_ptr) + i : i;
        if (j >= NUM_SRC) j = j - NUM_SRC;
        if (!hit && bus.req_valid[j]) begin
          hit      = 1'b1;
          win      = 3'(j);
          win_dest = bus.req_dest[j*5 +: 5];
        end
      end
      if (hit) gnt[win] = 1'b1;
    end
  end

  assign bus.req_ready = gnt;

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:    state_nx = S_INIT_WR;
      S_INIT_WR: state_nx = S_ARB;
      default:   state_nx = S_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nx;
  end

  // Write port registers. Writes to $zero are acknowledged but dropped,
  // so reg_wr and the write counter only move for non-zero destinations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wd_sel    <= '0;
      bus.wr_reg    <= '0;
      bus.reg_wr    <= 1'b0;
      bus.init_done <= 1'b0;
      bus.wr_count  <= '0;
      rr_ptr        <= '0;
    end else begin
      case (state)
        S_INIT: begin
          // Init write ignores wb_hold: it must land before any source.
          bus.wd_sel   <= 3'd7;
          bus.wr_reg   <= 5'(SP_REG);
          bus.reg_wr   <= 1'b1;
          bus.wr_count <= 16'd1;
        end
        S_INIT_WR: begin
          bus.reg_wr    <= 1'b0;
          bus.init_done <= 1'b1;
        end
        default: begin
          if (hit) begin
            bus.wd_sel <= win;
            bus.wr_reg <= win_dest;
            if (win_dest != 5'd0) begin
              bus.reg_wr   <= 1'b1;
              bus.wr_count <= bus.wr_count + 16'd1;
            end else begin
              bus.reg_wr <= 1'b0;
            end
            rr_ptr <= (int'(win) == NUM_SRC - 1) ? 3'd0 : win + 3'd1;
          end else begin
            bus.reg_wr <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regwrite_sequencer.sv
// tb_regwrite_sequencer: drives one fixed-priority and one round-robin
// instance with identical stimulus. A behavioural model (per instance)
// predicts grant and write-port values, compared every falling edge;
// directed steps pin the model with literal expectations, then a random
// phase with occasional resets runs.
module tb_regwrite_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  req_valid = '0;
  logic [34:0] req_dest = '0;
  logic        hold = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regwrite_sequencer_if b0 ();
  regwrite_sequencer_if b1 ();

  assign b0.req_valid = req_valid;
  assign b0.req_dest  = req_dest;
  assign b0.wb_hold   = hold;
  assign b1.req_valid = req_valid;
  assign b1.req_dest  = req_dest;
  assign b1.wb_hold   = hold;

  regwrite_sequencer #(.NUM_SRC(7), .SP_REG(29), .RR_MODE(1'b0)) u_fix (
    .clk(clk), .reset_n(rst_n), .bus(b0)
  );
  regwrite_sequencer #(.NUM_SRC(7), .SP_REG(29), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .reset_n(rst_n), .bus(b1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = init write pending, 1 = init write on the port, 2 = arbitrating
  int m_phase [2];
  int m_sel   [2];
  int m_wr    [2];
  int m_we    [2];
  int m_done  [2];
  int m_cnt   [2];
  int m_ptr   [2];
  int m_mode  [2] = '{0, 1};

  task automatic model_step(input int d, input logic [6:0] rdy, input logic [2:0] sel,
                            input logic [4:0] wr, input logic we, input logic done,
                            input logic [15:0] cnt);
    int k;
    int dst;
    logic [6:0] e_rdy;
    string s;
    k = -1;
    e_rdy = '0;
    s = $sformatf("dut%0d", d);
    if (!rst_n) begin
      m_phase[d] = 0; m_sel[d] = 0; m_wr[d] = 0; m_we[d] = 0;
      m_done[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
    end else if (m_phase[d] == 2 && !hold) begin
      for (int i = 0; i < 7; i++) begin
        int j;
        j = (m_mode[d] != 0) ? (m_ptr[d] + i) % 7 : i;
        if (k < 0 && req_valid[j]) k = j;
      end
    end
    if (k >= 0) e_rdy[k] = 1'b1;
    chk({s, ".req_ready"}, rdy, e_rdy);
    chk({s, ".wd_sel"}, sel, m_sel[d]);
    chk({s, ".wr_reg"}, wr, m_wr[d]);
    chk({s, ".reg_wr"}, we, m_we[d]);
    chk({s, ".init_done"}, done, m_done[d]);
    chk({s, ".wr_count"}, cnt, m_cnt[d]);
    if (rst_n) begin
      if (m_phase[d] == 0) begin
        m_sel[d] = 7; m_wr[d] = 29; m_we[d] = 1; m_cnt[d] = 1; m_phase[d] = 1;
      end else if (m_phase[d] == 1) begin
        m_we[d] = 0; m_done[d] = 1; m_phase[d] = 2;
      end else if (k >= 0) begin
        dst = int'(req_dest[k*5 +: 5]);
        m_sel[d] = k;
        m_wr[d]  = dst;
        m_we[d]  = (dst != 0) ? 1 : 0;
        if (dst != 0) m_cnt[d] = (m_cnt[d] + 1) % 65536;
        m_ptr[d] = (k + 1) % 7;
      end else begin
        m_we[d] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, b0.req_ready, b0.wd_sel, b0.wr_reg, b0.reg_wr, b0.init_done, b0.wr_count);
    model_step(1, b1.req_ready, b1.wd_sel, b1.wr_reg, b1.reg_wr, b1.init_done, b1.wr_count);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int k, input logic [4:0] v);
    req_dest[k*5 +: 5] = v;
  endtask

  int saved;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst.reg_wr", b1.reg_wr, 0);
    chk("rst.wr_count", b1.wr_count, 0);
    chk("rst.wd_sel", b1.wd_sel, 0);
    rst_n = 1'b1;

    // init sequence
    step();
    chk("init.wd_sel", b1.wd_sel, 7);
    chk("init.wr_reg", b1.wr_reg, 29);
    chk("init.reg_wr", b1.reg_wr, 1);
    chk("init.wr_count", b1.wr_count, 1);
    chk("init.done_early", b1.init_done, 0);
    step();
    chk("init2.reg_wr", b1.reg_wr, 0);
    chk("init2.init_done", b1.init_done, 1);

    // single request, source 0 -> r8
    req_valid = 7'h01; set_dest(0, 5'd8);
    #1 chk("single.ready", b1.req_ready, 7'h01);
    step();
    req_valid = '0;
    chk("single.wd_sel", b1.wd_sel, 0);
    chk("single.wr_reg", b1.wr_reg, 8);
    chk("single.reg_wr", b1.reg_wr, 1);
    chk("single.wr_count", b1.wr_count, 2);

    // grant source 6 alone so the round-robin pointer wraps to 0
    req_valid = 7'h40; set_dest(6, 5'd6);
    step();
    req_valid = 7'h7f;
    for (int k = 0; k < 7; k++) set_dest(k, 5'(k + 1));
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr.ready", b1.req_ready, 32'd1 << (c % 7));
      step();
      chk("rr.wd_sel", b1.wd_sel, c % 7);
      chk("rr.wr_reg", b1.wr_reg, (c % 7) + 1);
      chk("rr.reg_wr", b1.reg_wr, 1);
    end

    // fixed priority: source 2 beats 5 until it drops
    req_valid = 7'b0100100;
    for (int c = 0; c < 3; c++) begin
      #1 chk("fix.ready2", b0.req_ready, 7'h04);
      step();
      chk("fix.wd_sel2", b0.wd_sel, 2);
    end
    req_valid = 7'b0100000;
    #1 chk("fix.ready5", b0.req_ready, 7'h20);
    step();
    chk("fix.wd_sel5", b0.wd_sel, 5);

    // write to $zero: acknowledged, dropped, not counted
    req_valid = 7'h08; set_dest(3, 5'd0);
    saved = m_cnt[1];
    #1 chk("zero.ready", b1.req_ready, 7'h08);
    step();
    req_valid = '0;
    chk("zero.reg_wr", b1.reg_wr, 0);
    chk("zero.wd_sel", b1.wd_sel, 3);
    chk("zero.wr_count", b1.wr_count, saved);

    // hold blocks grants for 3 cycles
    req_valid = 7'h10; set_dest(4, 5'd12); hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold.ready", b1.req_ready, 0);
      step();
      chk("hold.reg_wr", b1.reg_wr, 0);
    end
    hold = 1'b0;
    #1 chk("unhold.ready", b1.req_ready, 7'h10);
    step();
    req_valid = '0;
    chk("unhold.reg_wr", b1.reg_wr, 1);
    chk("unhold.wr_reg", b1.wr_reg, 12);

    // reset mid-write
    rst_n = 1'b0;
    #1;
    chk("midrst.reg_wr", b1.reg_wr, 0);
    chk("midrst.init_done", b1.init_done, 0);
    chk("midrst.wr_count", b1.wr_count, 0);
    chk("midrst.ready", b1.req_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reinit.wd_sel", b1.wd_sel, 7);
    chk("reinit.wr_reg", b1.wr_reg, 29);
    chk("reinit.reg_wr", b1.reg_wr, 1);
    chk("reinit.wr_count", b1.wr_count, 1);
    step();
    chk("reinit.init_done", b1.init_done, 1);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 1) == 0) req_valid = 7'($urandom);
      else                           req_valid = 7'($urandom) & 7'($urandom);
      hold = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 7; k++) begin
        if ($urandom_range(0, 3) == 0)
          set_dest(k, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      end
    end
    step();
    rst_n = 1'b1;
    req_valid = '0;
    hold = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regwrite_sequencer.md
Name: regwrite_sequencer

Overview:
- Owns the single register-bank write port. Sequences the write-data mux selector, the destination register and the write enable.
- Arbitrates between seven write-back sources, one per mux input 0..6 (e.g. ALU, load data, HI, LO, shifter, LUI, PC link).
- After every reset it performs one stack-pointer initialisation write using mux input 7 (constant 227).
- Sits between the control unit and the register bank plus its write-data mux.

Parameters:
- NUM_SRC, 7, number of requesters; fixed at 7, mapped 1:1 to mux selector 0..6.
- SP_REG, 29, destination register of the post-reset init write.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  input  7  bit k: source k has a pending write.
- req_dest  input  35  bits [5k+4:5k]: destination register of source k.
- wb_hold  input  1  control-unit stall; blocks new grants while high.
- req_ready  output  7  one-hot grant pulse, combinational; handshake completes when req_valid[k] & req_ready[k].
- wd_sel  output  3  registered write-data mux selector.
- wr_reg  output  5  registered destination register number.
- reg_wr  output  1  registered register-bank write enable.
- init_done  output  1  high once the SP init write has been issued.
- wr_count  output  16  registered count of committed writes with reg_wr=1, init write included.

Behaviour:
- Reset asserted, asynchronous: state=S_INIT, wd_sel=0, wr_reg=0, reg_wr=0, init_done=0, wr_count=0, rr_ptr=0, req_ready=0.
- S_INIT, first rising edge after reset_n goes high:
  - wd_sel<=7, wr_reg<=SP_REG, reg_wr<=1, wr_count<=1, state<=S_INIT_WR.
  - wb_hold is ignored for the init write.
- S_INIT_WR, next edge: reg_wr<=0, init_done<=1, state<=S_ARB.
- req_ready is 0 in S_INIT and S_INIT_WR. It is also 0 while reset_n is low.
- S_ARB, combinational grant:
  - If wb_hold=0 and any req_valid is set, select exactly one winner k.
  - RR_MODE=1: first valid index starting at rr_ptr, scanning upward and wrapping from 6 to 0.
  - RR_MODE=0: lowest valid index.
  - req_ready[k]=1 for the winner; all other bits are 0.
  - If wb_hold=1 or no requests are valid, req_ready=0.
- S_ARB, edge with a grant to k:
  - wd_sel<=k, wr_reg<=req_dest[k].
  - reg_wr<=1 if the destination is non-zero. If the destination is 0, reg_wr<=0 and the request is still acknowledged (the write to $zero is dropped).
  - wr_count increments only when reg_wr is loaded with 1.
  - rr_ptr<=(k==6)?0:k+1.
- S_ARB, edge without a grant: reg_wr<=0; wd_sel, wr_reg and rr_ptr hold.
- Latency and throughput:
  - The write appears on the outputs 1 cycle after the grant cycle.
  - Back-to-back grants are allowed: reg_wr stays high across consecutive cycles with distinct wd_sel/wr_reg values.
  - Full throughput is 1 write per cycle.
- Selector 7 is never driven in S_ARB; it is reserved for the init write.
- Requesters must hold req_valid and req_dest stable until acknowledged. The block does not latch unacknowledged requests.
- wb_hold rising in the same cycle as a request: no grant, and the request waits. A pending registered write still completes on the ports; the hold only blocks the next grant.
- wr_count wraps from 0xFFFF to 0x0000.
- Reset asserted mid-operation: any in-flight write is aborted (reg_wr drops immediately) and the init sequence re-runs after release.

Test Plan:
- Reset release, no requests → cycle 1: reg_wr=1, wd_sel=7, wr_reg=29. Cycle 2: reg_wr=0, init_done=1. wr_count=1.
- Single request: source 0 valid, dest 8, after init → req_ready=0000001 in the same cycle. Next cycle: wd_sel=0, wr_reg=8, reg_wr=1. wr_count=2.
- RR_MODE=1, all 7 sources valid, dests 1..7, held valid for 8 cycles:
  - Grant order 0,1,2,3,4,5,6,0.
  - reg_wr continuously high; wd_sel follows the same order.
- RR_MODE=0, sources 2 and 5 valid → source 2 is granted repeatedly while valid. Source 5 is granted only after source 2 drops.
- Source 3 valid with dest 0 → req_ready[3] pulses; next cycle reg_wr=0, wd_sel=3; wr_count is unchanged.
- wb_hold=1 for 3 cycles with source 4 valid → req_ready=0 and reg_wr=0 throughout.
  - After hold drops, source 4 is granted in the same cycle.
  - Then assert reset_n=0 mid-write → reg_wr=0 immediately, and the init write repeats after release.
